// File: rtl/cache_pkg.sv
// Shared definitions for the N-way cache controller: FSM encodings and
// elaboration-time helpers for locating nodes in the PLRU tree.
package cache_pkg;

  localparam logic [1:0] CHECK     = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] FILL      = 2'd2;

  // Depth of tree node i (root is level 0).
  function automatic int node_level(input int node);
    return $clog2(node + 2) - 1;
  endfunction

  // Position of node i among the nodes of its own level.
  function automatic int node_prefix(input int node);
    return node - ((1 << node_level(node)) - 1);
  endfunction

  // Tree node visited at a given level on the path to way w.
  function automatic int path_node(input int way, input int level, input int depth);
    return ((1 << level) - 1) + (way >> (depth - level));
  endfunction

  // Branch taken at a given level on the path to way w (0 = left, 1 = right).
  function automatic logic path_dir(input int way, input int level, input int depth);
    return 1'((way >> (depth - 1 - level)) & 1);
  endfunction

endpackage

// File: rtl/cache_control_nway_if.sv
// CPU request and physical-memory line handshakes seen by the cache controller.
interface cache_control_nway_if;
  logic mem_read;
  logic mem_write;
  logic mem_resp;
  logic pmem_read;
  logic pmem_write;
  logic pmem_resp;

  // Controller side: answers the CPU and masters the physical-memory port.
  modport master (
    input  mem_read, mem_write, pmem_resp,
    output mem_resp, pmem_read, pmem_write
  );

  // Environment side: CPU plus physical memory.
  modport slave (
    output mem_read, mem_write, pmem_resp,
    input  mem_resp, pmem_read, pmem_write
  );
endinterface

// File: rtl/plru_tree.sv
// Combinational tree pseudo-LRU: victim choice (invalid way first) and the
// updated tree bits for an accessed way. All tree indices are elaboration constants.
module plru_tree
  import cache_pkg::*;
#(
  parameter int WAYS = 4
) (
  input  logic [WAYS-2:0]         plru_bits,
  input  logic [WAYS-1:0]         valid,
  input  logic [$clog2(WAYS)-1:0] access_way,
  output logic [$clog2(WAYS)-1:0] victim,
  output logic [WAYS-2:0]         plru_next
);
  localparam int DEPTH = $clog2(WAYS);

  logic [DEPTH-1:0] path_match [WAYS];
  logic [WAYS-1:0]  is_lru;
  logic [DEPTH-1:0] lru_way;
  logic [DEPTH-1:0] free_way;
  logic             free_found;

  // A way is the PLRU leaf when every bit on its path points toward it.
  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    for (genvar gl = 0; gl < DEPTH; gl++) begin : g_lvl
      localparam int NODE = path_node(gi, gl, DEPTH);
      assign path_match[gi][gl] = (plru_bits[NODE] == path_dir(gi, gl, DEPTH));
    end
    assign is_lru[gi] = &path_match[gi];
  end

  // Nodes on the accessed path are turned to point away from it.
  for (genvar gi = 0; gi < WAYS - 1; gi++) begin : g_node
    localparam int LVL = node_level(gi);
    localparam int PFX = node_prefix(gi);
    logic [DEPTH-1:0] way_prefix;
    assign way_prefix    = access_way >> (DEPTH - LVL);
    assign plru_next[gi] = (way_prefix == DEPTH'(PFX)) ? ~access_way[DEPTH-1-LVL]
                                                       : plru_bits[gi];
  end

  always_comb begin
    lru_way    = '0;
    free_way   = '0;
    free_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (is_lru[w]) lru_way = DEPTH'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) begin
        free_found = 1'b1;
        free_way   = DEPTH'(w);
      end
    end
    victim = free_found ? free_way : lru_way;
  end

endmodule

// File: rtl/cache_control_nway.sv
// N-way write-back, write-allocate cache controller with tree PLRU replacement,
// a held victim register across writeback/fill, and saturating hit/miss counters.
module cache_control_nway
  import cache_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  cache_control_nway_if.master    bus,
  input  logic [WAYS-1:0]         hit,
  input  logic [WAYS-1:0]         valid_in,
  input  logic [WAYS-1:0]         dirty_in,
  input  logic [WAYS-2:0]         plru_in,
  output logic                    plru_load,
  output logic [WAYS-2:0]         plru_out,
  output logic [$clog2(WAYS)-1:0] way_sel,
  output logic                    data_we,
  output logic                    data_fill,
  output logic                    wb_addr_sel,
  output logic [WAYS-1:0]         load_tag,
  output logic [WAYS-1:0]         load_valid,
  output logic [WAYS-1:0]         load_dirty,
  output logic                    valid_out,
  output logic                    dirty_out,
  input  logic                    clr_stats,
  output logic [CNT_W-1:0]        hit_count,
  output logic [CNT_W-1:0]        miss_count
);
  localparam int WW = $clog2(WAYS);

  logic [1:0]       state_q, state_next;
  logic [WW-1:0]    victim_q;
  logic             retry_q;
  logic [WW-1:0]    victim;
  logic [WW-1:0]    hit_way;
  logic [WAYS-2:0]  plru_upd;
  logic             req;
  logic             resp;
  logic             miss_start;
  logic             fill_done;
  logic [WAYS-1:0]  victim_mask;
  logic [CNT_W-1:0] cnt_q [2];
  logic [1:0]       cnt_inc;

  plru_tree #(.WAYS(WAYS)) u_plru (
    .plru_bits  (plru_in),
    .valid      (valid_in),
    .access_way (hit_way),
    .victim     (victim),
    .plru_next  (plru_upd)
  );

  assign req         = bus.mem_read | bus.mem_write;
  assign victim_mask = WAYS'(1) << victim_q;

  // Lowest set hit bit wins if the datapath ever reports more than one.
  always_comb begin
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit[w]) hit_way = WW'(w);
    end
  end

  always_comb begin
    state_next     = state_q;
    resp           = 1'b0;
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    plru_load      = 1'b0;
    plru_out       = '0;
    way_sel        = '0;
    data_we        = 1'b0;
    data_fill      = 1'b0;
    wb_addr_sel    = 1'b0;
    load_tag       = '0;
    load_valid     = '0;
    load_dirty     = '0;
    valid_out      = 1'b0;
    dirty_out      = 1'b0;
    miss_start     = 1'b0;
    fill_done      = 1'b0;
    case (state_q)
      CHECK: begin
        if (req && |hit) begin
          resp      = 1'b1;
          way_sel   = hit_way;
          plru_load = 1'b1;
          plru_out  = plru_upd;
          if (bus.mem_write) begin
            data_we             = 1'b1;
            load_dirty[hit_way] = 1'b1;
            dirty_out           = 1'b1;
          end
        end else if (req) begin
          miss_start = 1'b1;
          state_next = (valid_in[victim] && dirty_in[victim]) ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        bus.pmem_write = 1'b1;
        wb_addr_sel    = 1'b1;
        way_sel        = victim_q;
        if (bus.pmem_resp) state_next = FILL;
      end
      FILL: begin
        bus.pmem_read = 1'b1;
        way_sel       = victim_q;
        if (bus.pmem_resp) begin
          data_fill  = 1'b1;
          load_tag   = victim_mask;
          load_valid = victim_mask;
          load_dirty = victim_mask;
          valid_out  = 1'b1;
          fill_done  = 1'b1;
          state_next = CHECK;
        end
      end
      default: state_next = CHECK;
    endcase
    // Array contents must not be disturbed while reset is held.
    if (rst) begin
      data_we    = 1'b0;
      data_fill  = 1'b0;
      load_tag   = '0;
      load_valid = '0;
      load_dirty = '0;
      plru_load  = 1'b0;
      plru_out   = '0;
    end
  end

  assign bus.mem_resp = resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CHECK;
      victim_q <= '0;
      retry_q  <= 1'b0;
    end else begin
      state_q <= state_next;
      if (miss_start) victim_q <= victim;
      if (fill_done) retry_q <= 1'b1;
      else if (resp) retry_q <= 1'b0;
    end
  end

  // The response that completes a miss is not counted as a hit.
  assign cnt_inc[0] = resp & ~retry_q;
  assign cnt_inc[1] = miss_start;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (rst || clr_stats) cnt_q[gi] <= '0;
      else if (cnt_inc[gi] && cnt_q[gi] != '1) cnt_q[gi] <= cnt_q[gi] + 1'b1;
    end
  end

  assign hit_count  = cnt_q[0];
  assign miss_count = cnt_q[1];

endmodule

// File: tb/tb_cache_control_nway.sv
// Directed bench for cache_control_nway (WAYS=4): hits, clean and dirty misses,
// reset during writeback and clear-vs-increment on the statistics counters.
module tb_cache_control_nway;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  hit, valid_in, dirty_in;
  logic [2:0]  plru_in;
  logic        plru_load;
  logic [2:0]  plru_out;
  logic [1:0]  way_sel;
  logic        data_we, data_fill, wb_addr_sel;
  logic [3:0]  load_tag, load_valid, load_dirty;
  logic        valid_out, dirty_out;
  logic        clr_stats;
  logic [31:0] hit_count, miss_count;
  logic [25:0] all_outs;
  int          vec_cnt = 0;
  int          err_cnt = 0;

  cache_control_nway_if bus_if ();

  always #5 clk = ~clk;

  cache_control_nway #(.WAYS(4), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .hit         (hit),
    .valid_in    (valid_in),
    .dirty_in    (dirty_in),
    .plru_in     (plru_in),
    .plru_load   (plru_load),
    .plru_out    (plru_out),
    .way_sel     (way_sel),
    .data_we     (data_we),
    .data_fill   (data_fill),
    .wb_addr_sel (wb_addr_sel),
    .load_tag    (load_tag),
    .load_valid  (load_valid),
    .load_dirty  (load_dirty),
    .valid_out   (valid_out),
    .dirty_out   (dirty_out),
    .clr_stats   (clr_stats),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  assign all_outs = {bus_if.mem_resp, bus_if.pmem_read, bus_if.pmem_write, plru_load,
                     plru_out, way_sel, data_we, data_fill, wb_addr_sel, load_tag,
                     load_valid, load_dirty, valid_out, dirty_out};

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr_stats = 1'b0;
    hit = '0; valid_in = '0; dirty_in = '0; plru_in = '0;
    bus_if.mem_read = 1'b0; bus_if.mem_write = 1'b0; bus_if.pmem_resp = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    // 1: reset, idle
    check_vec("rst_outs", 64'(all_outs), 64'h0);
    check_vec("rst_hit_count", 64'(hit_count), 64'd0);
    check_vec("rst_miss_count", 64'(miss_count), 64'd0);
    tick();

    // 2: read hit on way 2
    bus_if.mem_read = 1'b1; hit = 4'b0100; valid_in = 4'b1111; plru_in = 3'b000;
    #1;
    check_vec("rd_hit_resp", 64'(bus_if.mem_resp), 64'd1);
    check_vec("rd_hit_way", 64'(way_sel), 64'd2);
    check_vec("rd_hit_plru_load", 64'(plru_load), 64'd1);
    check_vec("rd_hit_plru_out", 64'(plru_out), 64'b100);
    check_vec("rd_hit_data_we", 64'(data_we), 64'd0);
    tick();
    bus_if.mem_read = 1'b0; hit = '0;
    check_vec("rd_hit_count", 64'(hit_count), 64'd1);

    // 3: write hit on way 1
    bus_if.mem_write = 1'b1; hit = 4'b0010;
    #1;
    check_vec("wr_hit_resp", 64'(bus_if.mem_resp), 64'd1);
    check_vec("wr_hit_data_we", 64'(data_we), 64'd1);
    check_vec("wr_hit_load_dirty", 64'(load_dirty), 64'b0010);
    check_vec("wr_hit_dirty_out", 64'(dirty_out), 64'd1);
    check_vec("wr_hit_plru_out", 64'(plru_out), 64'b001);
    tick();
    bus_if.mem_write = 1'b0; hit = '0;
    check_vec("wr_hit_count", 64'(hit_count), 64'd2);

    // 4: clean miss, way 2 invalid
    bus_if.mem_read = 1'b1; valid_in = 4'b1011; dirty_in = 4'b0000; plru_in = 3'b000;
    #1;
    check_vec("cm_check_resp", 64'(bus_if.mem_resp), 64'd0);
    check_vec("cm_check_pmem_read", 64'(bus_if.pmem_read), 64'd0);
    tick();
    check_vec("cm_miss_count", 64'(miss_count), 64'd1);
    for (int i = 0; i < 5; i++) begin
      bus_if.pmem_resp = (i == 4);
      #1;
      check_vec($sformatf("cm_pmem_read_c%0d", i), 64'(bus_if.pmem_read), 64'd1);
      check_vec($sformatf("cm_pmem_write_c%0d", i), 64'(bus_if.pmem_write), 64'd0);
      if (i == 0) check_vec("cm_way_sel", 64'(way_sel), 64'd2);
      if (i == 3) check_vec("cm_no_early_fill", 64'(data_fill), 64'd0);
      if (i == 4) begin
        check_vec("cm_data_fill", 64'(data_fill), 64'd1);
        check_vec("cm_load_tag", 64'(load_tag), 64'b0100);
        check_vec("cm_load_valid", 64'(load_valid), 64'b0100);
        check_vec("cm_load_dirty", 64'(load_dirty), 64'b0100);
        check_vec("cm_valid_out", 64'(valid_out), 64'd1);
        check_vec("cm_dirty_out", 64'(dirty_out), 64'd0);
      end
      tick();
    end
    bus_if.pmem_resp = 1'b0; hit = 4'b0100; valid_in = 4'b1111;
    #1;
    check_vec("cm_retry_pmem_read", 64'(bus_if.pmem_read), 64'd0);
    check_vec("cm_retry_resp", 64'(bus_if.mem_resp), 64'd1);
    tick();
    bus_if.mem_read = 1'b0; hit = '0;
    check_vec("cm_hit_count", 64'(hit_count), 64'd2);
    check_vec("cm_miss_count_after", 64'(miss_count), 64'd1);

    // 5: dirty miss, all valid, PLRU picks way 2
    bus_if.mem_read = 1'b1; valid_in = 4'b1111; dirty_in = 4'b0100; plru_in = 3'b011;
    #1;
    check_vec("dm_check_pmem_write", 64'(bus_if.pmem_write), 64'd0);
    tick();
    check_vec("dm_miss_count", 64'(miss_count), 64'd2);
    for (int i = 0; i < 3; i++) begin
      bus_if.pmem_resp = (i == 2);
      #1;
      check_vec($sformatf("dm_pmem_write_c%0d", i), 64'(bus_if.pmem_write), 64'd1);
      if (i == 0) begin
        check_vec("dm_wb_addr_sel", 64'(wb_addr_sel), 64'd1);
        check_vec("dm_wb_way_sel", 64'(way_sel), 64'd2);
        check_vec("dm_wb_pmem_read", 64'(bus_if.pmem_read), 64'd0);
      end
      tick();
    end
    bus_if.pmem_resp = 1'b0;
    #1;
    check_vec("dm_fill_pmem_write", 64'(bus_if.pmem_write), 64'd0);
    check_vec("dm_fill_pmem_read", 64'(bus_if.pmem_read), 64'd1);
    check_vec("dm_fill_way_sel", 64'(way_sel), 64'd2);
    bus_if.pmem_resp = 1'b1;
    #1;
    check_vec("dm_fill_load_valid", 64'(load_valid), 64'b0100);
    tick();
    bus_if.pmem_resp = 1'b0; hit = 4'b0100;
    #1;
    check_vec("dm_retry_resp", 64'(bus_if.mem_resp), 64'd1);
    tick();
    bus_if.mem_read = 1'b0; hit = '0;
    check_vec("dm_hit_count", 64'(hit_count), 64'd2);

    // 6: reset while in WRITEBACK, then clr_stats against a hit
    bus_if.mem_read = 1'b1; valid_in = 4'b1111; dirty_in = 4'b0100; plru_in = 3'b011;
    tick();
    check_vec("rw_in_writeback", 64'(bus_if.pmem_write), 64'd1);
    rst = 1'b1; bus_if.mem_read = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check_vec("rw_pmem_write", 64'(bus_if.pmem_write), 64'd0);
    check_vec("rw_pmem_read", 64'(bus_if.pmem_read), 64'd0);
    check_vec("rw_hit_count", 64'(hit_count), 64'd0);
    check_vec("rw_miss_count", 64'(miss_count), 64'd0);
    bus_if.mem_read = 1'b1; hit = 4'b0001; clr_stats = 1'b1;
    #1;
    check_vec("clr_hit_resp", 64'(bus_if.mem_resp), 64'd1);
    tick();
    clr_stats = 1'b0;
    check_vec("clr_hit_count", 64'(hit_count), 64'd0);
    tick();
    bus_if.mem_read = 1'b0; hit = '0;
    check_vec("post_clr_hit_count", 64'(hit_count), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
